// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, instruction FIFO, redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_base,
    input  logic [31:0] redirect_imm,
    input  logic        redirect_jalr,
    output logic        misalign_err
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

    state_t        state, state_next;
    logic          drop, drop_next;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic [31:0]   buf_inst [BUF_DEPTH];
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    logic [31:0]   tgt_sum;
    logic [31:0]   tgt;
    logic          tgt_misaligned;
    logic          live_redirect;
    logic          fifo_full;
    logic          accept;
    logic          rsp;
    logic          push;
    logic          pop;

    // Redirect target; JALR clears bit 0 before the alignment check.
    assign tgt_sum        = redirect_base + redirect_imm;
    assign tgt            = {tgt_sum[31:1], tgt_sum[0] & ~redirect_jalr};
    assign tgt_misaligned = (tgt[1:0] != 2'b00);
    assign live_redirect  = redirect && (state != HALT);

    // A slot is kept free for the outstanding response, so only issue below full.
    assign fifo_full  = (count == CW'(BUF_DEPTH));
    assign imem_req   = (state == REQ) && !fifo_full && !redirect;
    assign imem_addr  = pc;
    assign accept     = imem_req && imem_ready;
    assign rsp        = (state == WAIT) && imem_rvalid;
    assign push       = rsp && !drop && !live_redirect;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && !live_redirect;
    assign inst       = inst_valid ? buf_inst[rptr] : NOP_INST;
    assign inst_pc    = inst_valid ? buf_pc[rptr] : 32'h0;

    // Next-state and drop-flag logic; a redirect overrides the normal flow.
    always_comb begin
        state_next = state;
        drop_next  = drop;
        case (state)
            IDLE: state_next = REQ;
            REQ:  if (accept) state_next = WAIT;
            WAIT: if (imem_rvalid) begin
                      drop_next  = 1'b0;
                      state_next = REQ;
                  end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
        if (live_redirect) begin
            if (tgt_misaligned) begin
                state_next = HALT;
                drop_next  = 1'b0;
            end else if ((state == WAIT) && !imem_rvalid) begin
                state_next = WAIT;
                drop_next  = 1'b1;
            end else begin
                state_next = REQ;
                drop_next  = 1'b0;
            end
        end
    end

    // State, PC and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            drop         <= 1'b0;
            pc           <= RESET_PC;
            req_pc       <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            state <= state_next;
            drop  <= drop_next;
            if (live_redirect) begin
                if (tgt_misaligned) misalign_err <= 1'b1;
                else                pc           <= tgt;
            end else if (accept) begin
                req_pc <= pc;
                pc     <= pc + 32'd4;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (live_redirect) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wptr] <= imem_rdata;
            buf_pc[wptr]   <= req_pc;
        end
    end

endmodule
